packet_assembler: RTL and testbench
===================================

Name: packet_assembler

Overview:
- Front end of the receive path. Sits between the laser byte receiver (UART-style, one byte per `byte_valid` pulse) and the packet checksum/sequence stage.
- Hunts for a start-of-frame byte, then shifts in a fixed 36-byte (9-octet, 288-bit) TCP-style packet, octet1 MSB first.
- Presents the packet as a stable 288-bit bus with a one-cycle `ready` strobe.
- Aborts partial frames on inter-byte timeout.

Parameters:
- `SOF_BYTE`, 8'hA5, start-of-frame marker hunted for in IDLE.
- `NUM_BYTES`, 36, payload bytes per frame (9 octets x 4).
- `TIMEOUT_CYCLES`, 65536, max clk cycles allowed between consecutive bytes inside a frame.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `byte_in`  input  8  received byte; valid only when `byte_valid`=1.
- `byte_valid`  input  1  single-cycle strobe from the byte receiver.
- `packet`  output  288  last complete frame; byte 0 after SOF lands in [287:280], byte 35 in [7:0].
- `ready`  output  1  one-cycle pulse: `packet` just updated.
- `frame_err`  output  1  one-cycle pulse: partial frame discarded by timeout.
- `busy`  output  1  high while in COLLECT.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, `packet`=0, `ready`=0, `frame_err`=0, `busy`=0.
  - byte count=0, timeout count=0, shift register=0.
  - Reset mid-frame discards the partial frame with no `frame_err`.
- States:
  - IDLE:
    - `byte_valid` && `byte_in`==`SOF_BYTE` -> COLLECT; byte count=0, timeout count=0.
    - Any other byte is ignored.
  - COLLECT, on `byte_valid`:
    - Shift register <= {shift[279:0], `byte_in`}; byte count++; timeout count=0.
    - `SOF_BYTE` values here are data (no escaping).
    - On the edge that accepts byte `NUM_BYTES`-1:
      - `packet` <= {shift[279:0], `byte_in`}.
      - `ready` <= 1.
      - state <= IDLE.
  - COLLECT, no `byte_valid`:
    - Timeout count++.
    - When it reaches `TIMEOUT_CYCLES`-1: `frame_err` <= 1; state <= IDLE; partial data discarded; `packet` unchanged.
- Simultaneous byte and timeout expiry in the same cycle: the byte wins, and the timeout restarts.
- Latency:
  - `ready` and the new `packet` appear on the clock edge after the last byte's `byte_valid` cycle.
  - `ready` is high for exactly 1 cycle.
- Stability: `packet` changes only on frame completion, so it holds for at least 37 byte times. Downstream may sample it any number of cycles after `ready`.
- A byte arriving in the cycle `ready` is high is processed by IDLE (it may be the next SOF).
- `busy` = (state==COLLECT), registered.
- Width rules:
  - Byte count is 6 bits and never exceeds `NUM_BYTES`-1.
  - Timeout count width is $clog2(`TIMEOUT_CYCLES`) and saturates logically via the abort.
- No checksum or sequence checking here; that is the downstream stage's job.

Optional Feature:
- Macro `PKT_ASM_STATS_EN`.
- Defined: adds outputs `good_frames[15:0]` and `bad_frames[15:0]`.
  - `good_frames` increments with each `ready` pulse.
  - `bad_frames` increments with each `frame_err` pulse.
  - Both saturate at 16'hFFFF and clear on `reset`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `lasernet_pkg`:
  - `PACKET_BYTES`=36, `PACKET_W`=288, `OCTET_W`=32, `SOF_DEFAULT`=8'hA5.
  - Assembler state enum {IDLE, COLLECT}.
- One sub-module is natural: `pkt_timeout_timer`.
  - Inputs: clear and run.
  - Output: expire at `TIMEOUT_CYCLES`-1.
  - Reused by the transmit-side ACK wait logic.

Test Plan:
- Normal frame: send A5 then bytes 00..23 (hex) -> one `ready` pulse 1 cycle after byte 23; `packet` = 288'h000102...2223; `frame_err` never asserted.
- Noise before SOF: bytes 11, 22, A4, then A5 + 36 bytes of 5A -> the pre-SOF bytes are ignored; `packet` = all 5A; exactly one `ready`.
- Timeout (`TIMEOUT_CYCLES`=100): A5 + 10 bytes, then idle 100 cycles -> `frame_err` pulses once at the 99th idle cycle; `packet` unchanged. A following full frame assembles correctly.
- Byte at expiry: A5 + 5 bytes; 6th byte arrives exactly on the idle cycle count 99 -> no `frame_err`; frame completes normally.
- SOF as data and back-to-back frames: a frame containing A5 payload bytes, immediately followed by A5 in the `ready` cycle + a second frame -> both frames are delivered intact with two `ready` pulses.
- Async reset mid-frame: assert `reset` between clk edges after 20 bytes -> all outputs 0 immediately; no `ready` or `frame_err`. With `PKT_ASM_STATS_EN`, counters are 0 and then count 1 good / 1 bad over subsequent good and timed-out frames.

Source files
------------

// File: rtl/lasernet_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lasernet_pkg                                                     |
// | Shared frame constants and assembler state encoding.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lasernet_pkg;

  localparam int PACKET_BYTES = 36;
  localparam int PACKET_W     = 288;
  localparam int OCTET_W      = 32;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_timeout_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pkt_timeout_timer                                                |
// | Counts run cycles since clear; expire marks the run cycle whose  |
// | increment would bring the count to TIMEOUT_CYCLES-1.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pkt_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  // clear has priority so a byte landing on the expiry cycle restarts the wait
  assign expire = run && !clear && (count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | packet_assembler                                                 |
// | Hunts SOF, shifts in a fixed-length frame, strobes ready, aborts |
// | on inter-byte timeout. Optional macro: PKT_ASM_STATS_EN.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module packet_assembler
  import lasernet_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         NUM_BYTES      = PACKET_BYTES,
  parameter int         TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic [NUM_BYTES*8-1:0] packet,
  output logic                   ready,
  output logic                   frame_err,
  output logic                   busy
`ifdef PKT_ASM_STATS_EN
  ,
  output logic [15:0]            good_frames,
  output logic [15:0]            bad_frames
`endif
);

  localparam int W = NUM_BYTES * 8;
  localparam logic [5:0] LAST = 6'(NUM_BYTES - 1);

  asm_state_t   state;
  logic [5:0]   byte_cnt;
  logic [W-1:0] shift;
  logic         expire;

  pkt_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (reset),
    .clear  ((state == IDLE) || byte_valid),
    .run    ((state == COLLECT) && !byte_valid),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      packet    <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      byte_cnt  <= '0;
      shift     <= '0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid && (byte_in == SOF_BYTE)) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            byte_cnt <= '0;
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            shift <= {shift[W-9:0], byte_in};
            if (byte_cnt == LAST) begin
              packet   <= {shift[W-9:0], byte_in};
              ready    <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 6'd1;
            end
          end else if (expire) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            byte_cnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PKT_ASM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_frames <= '0;
      bad_frames  <= '0;
    end else begin
      if (ready && (good_frames != 16'hFFFF)) good_frames <= good_frames + 16'd1;
      if (frame_err && (bad_frames != 16'hFFFF)) bad_frames <= bad_frames + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_packet_assembler                                              |
// | Event-stream stimulus checked against a frame-level model.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_packet_assembler;
  import lasernet_pkg::*;

  localparam int T   = 100;
  localparam int NB  = 36;
  localparam int SOF = 8'hA5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic [287:0] packet;
  logic         ready, frame_err, busy;
`ifdef PKT_ASM_STATS_EN
  logic [15:0]  good_frames, bad_frames;
`endif

  int errors = 0;
  int checks = 0;
  int ev_idx = 0;
  int tot_good = 0;
  int tot_bad = 0;

  int           ev[$];
  logic [287:0] got[$];
  int           got_ready_at[$];
  int           got_err_at[$];
  logic [287:0] exp_frames[$];
  int           exp_ready_at[$];
  int           exp_err_at[$];

  packet_assembler #(
    .SOF_BYTE(8'hA5), .NUM_BYTES(NB), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .packet(packet), .ready(ready), .frame_err(frame_err), .busy(busy)
`ifdef PKT_ASM_STATS_EN
    , .good_frames(good_frames), .bad_frames(bad_frames)
`endif
  );

  always #5 clk = ~clk;

  // negedge in event slot k observes what the edge ending slot k-1 produced
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        got.push_back(packet);
        got_ready_at.push_back(ev_idx);
      end
      if (frame_err) got_err_at.push_back(ev_idx);
    end
  end

  function automatic logic [287:0] pack(input int q[$]);
    logic [287:0] p;
    p = '0;
    foreach (q[i]) p = {p[279:0], 8'(q[i])};
    return p;
  endfunction

  // Frame-level reference: ev[i] >= 0 is a byte slot, -1 is an idle slot
  task automatic model();
    bit in_frame;
    int q[$];
    int gap;
    in_frame = 1'b0;
    gap = 0;
    exp_frames.delete(); exp_ready_at.delete(); exp_err_at.delete();
    foreach (ev[i]) begin
      if (ev[i] >= 0) begin
        if (!in_frame) begin
          if (ev[i] == SOF) begin
            in_frame = 1'b1;
            q.delete();
            gap = 0;
          end
        end else begin
          q.push_back(ev[i]);
          gap = 0;
          if (q.size() == NB) begin
            exp_frames.push_back(pack(q));
            exp_ready_at.push_back(i + 1);
            in_frame = 1'b0;
          end
        end
      end else if (in_frame) begin
        gap++;
        if (gap == T - 1) begin
          exp_err_at.push_back(i + 1);
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic drive_ev();
    got.delete(); got_ready_at.delete(); got_err_at.delete();
    foreach (ev[i]) begin
      ev_idx = i;
      if (ev[i] >= 0) begin
        byte_valid = 1'b1;
        byte_in    = 8'(ev[i]);
      end else begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic add_bytes(input int n, input int fixed);
    for (int k = 0; k < n; k++) ev.push_back(fixed >= 0 ? fixed : int'($urandom_range(0, 255)));
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) ev.push_back(-1);
  endtask

  task automatic run_and_check(input string name);
    bit bad;
    add_idle(3);
    model();
    drive_ev();
    checks++;
    if (got.size() != exp_frames.size()) begin
      errors++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, got.size(), exp_frames.size());
    end
    for (int i = 0; i < got.size() && i < exp_frames.size(); i++) begin
      checks++;
      if (got[i] !== exp_frames[i]) begin
        errors++;
        $display("FAIL %s packet[%0d]: got %h expected %h", name, i, got[i], exp_frames[i]);
      end
    end
    bad = (got_ready_at.size() != exp_ready_at.size());
    for (int i = 0; !bad && i < got_ready_at.size(); i++) bad = (got_ready_at[i] != exp_ready_at[i]);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s ready_timing: got %0d pulses (first slot %0d) expected %0d (first slot %0d)", name,
               got_ready_at.size(), got_ready_at.size() > 0 ? got_ready_at[0] : -1,
               exp_ready_at.size(), exp_ready_at.size() > 0 ? exp_ready_at[0] : -1);
    end
    bad = (got_err_at.size() != exp_err_at.size());
    for (int i = 0; !bad && i < got_err_at.size(); i++) bad = (got_err_at[i] != exp_err_at[i]);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s frame_err_timing: got %0d pulses (first slot %0d) expected %0d (first slot %0d)", name,
               got_err_at.size(), got_err_at.size() > 0 ? got_err_at[0] : -1,
               exp_err_at.size(), exp_err_at.size() > 0 ? exp_err_at[0] : -1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_idle: got %b expected 0", name, busy);
    end
    tot_good += exp_frames.size();
    tot_bad  += exp_err_at.size();
`ifdef PKT_ASM_STATS_EN
    checks++;
    if (good_frames !== 16'(tot_good) || bad_frames !== 16'(tot_bad)) begin
      errors++;
      $display("FAIL %s stats: got good=%0d bad=%0d expected good=%0d bad=%0d", name,
               good_frames, bad_frames, tot_good, tot_bad);
    end
`endif
    ev.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (packet !== '0 || ready !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got packet=%h ready=%b frame_err=%b busy=%b expected all 0",
               name, packet, ready, frame_err, busy);
    end
`ifdef PKT_ASM_STATS_EN
    checks++;
    if (good_frames !== 16'd0 || bad_frames !== 16'd0) begin
      errors++;
      $display("FAIL %s stats_zero: got good=%0d bad=%0d expected 0", name, good_frames, bad_frames);
    end
`endif
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tot_good = 0;
    tot_bad  = 0;
  endtask

  task automatic test_normal();
    ev.push_back(SOF);
    for (int k = 0; k < NB; k++) ev.push_back(k);
    run_and_check("normal");
    checks++;
    if (packet !== 288'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20212223) begin
      errors++;
      $display("FAIL normal_literal: got %h", packet);
    end
  endtask

  task automatic test_noise();
    ev = '{8'h11, 8'h22, 8'hA4, SOF};
    add_bytes(NB, 8'h5A);
    run_and_check("noise");
  endtask

  task automatic test_timeout();
    ev.push_back(SOF);
    add_bytes(10, -1);
    add_idle(T);
    ev.push_back(SOF);
    add_bytes(NB, -1);
    run_and_check("timeout");
  endtask

  task automatic test_byte_at_expiry();
    ev.push_back(SOF);
    add_bytes(5, -1);
    add_idle(T - 2);
    add_bytes(NB - 5, -1);
    run_and_check("byte_at_expiry");
  endtask

  task automatic test_back_to_back();
    ev.push_back(SOF);
    for (int k = 0; k < NB; k++) ev.push_back((k % 4 == 0) ? SOF : int'($urandom_range(0, 255)));
    ev.push_back(SOF);
    for (int k = 0; k < NB; k++) ev.push_back((k % 3 == 1) ? SOF : int'($urandom_range(0, 255)));
    run_and_check("back_to_back");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 300; n++) begin
        int pick;
        pick = int'($urandom_range(0, 99));
        if (pick < 2) add_idle(int'($urandom_range(T - 3, T + 1)));
        else if (pick < 14) add_idle(int'($urandom_range(1, 5)));
        else if (pick < 30) ev.push_back(SOF);
        else add_bytes(1, -1);
      end
      add_idle(T + 1);
      run_and_check("random");
    end
  endtask

  task automatic test_reset_mid_frame();
    ev.push_back(SOF);
    add_bytes(20, -1);
    drive_ev();
    ev.delete();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (got_ready_at.size() != 0 || got_err_at.size() != 0) begin
      errors++;
      $display("FAIL midframe_pulses: got ready=%0d frame_err=%0d expected 0 0",
               got_ready_at.size(), got_err_at.size());
    end
    tot_good = 0;
    tot_bad  = 0;
    ev.push_back(SOF);
    add_bytes(NB, -1);
    ev.push_back(SOF);
    add_bytes(7, -1);
    add_idle(T);
    run_and_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_noise();
    test_timeout();
    test_byte_at_expiry();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
